// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, memory-control bit positions and EX/MEM payload bundle
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_WB_W   = 2;
  localparam int PIPE_M_W    = 3;
  localparam int PIPE_RD_W   = 5;
  localparam int PIPE_MR_BIT = 1;
  localparam int PIPE_MW_BIT = 0;

  typedef struct packed {
    logic [PIPE_WB_W-1:0]   wb;
    logic [PIPE_M_W-1:0]    m;
    logic [PIPE_DATA_W-1:0] alu;
    logic [PIPE_DATA_W-1:0] wdata;
    logic [PIPE_RD_W-1:0]   rd;
  } ex_mem_payload_t;

endpackage

// File: rtl/pipe_payload_reg.sv
// rtl/pipe_payload_reg.sv - load-enabled payload register with synchronous clear
module pipe_payload_reg
  import pipe_pkg::*;
#(
  parameter type T = ex_mem_payload_t
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic load_i,
  input  T     d_i,
  output T     q_o
);

  T r_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_q <= '0;
    end else if (load_i) begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/ex_mem_stage_skid.sv
// rtl/ex_mem_stage_skid.sv - EX/MEM stage register with valid/ready handshake,
// optional 2-entry skid buffer, flush and valid-gated memory strobes
module ex_mem_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int WB_W   = PIPE_WB_W,
  parameter int M_W    = PIPE_M_W,
  parameter int RD_W   = PIPE_RD_W,
  parameter int MR_BIT = PIPE_MR_BIT,
  parameter int MW_BIT = PIPE_MW_BIT,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WB_W-1:0]   wb_i,
  input  logic [M_W-1:0]    m_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WB_W-1:0]   wb_o,
  output logic [M_W-1:0]    m_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [RD_W-1:0]   rd_o,
  output logic              mem_read_o,
  output logic              mem_write_o
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [RD_W-1:0]   rd;
  } payload_t;

  logic     r_main_valid;
  logic     r_skid_valid;
  payload_t r_main;
  payload_t r_skid;
  payload_t w_in_payload;
  payload_t w_main_d;
  logic     w_accept;
  logic     w_retire;
  logic     w_main_load_in;
  logic     w_main_load_skid;
  logic     w_skid_load;

  assign w_in_payload = '{wb: wb_i, m: m_i, alu: alu_i, wdata: wdata_i, rd: rd_i};

  // With the skid buffer, ready depends only on state (and reset), never on out_ready_i.
  generate
    if (SKID != 0) begin : g_ready_skid
      assign in_ready_o = ~r_skid_valid & ~rst_i;
    end else begin : g_ready_single
      assign in_ready_o = (~r_main_valid | out_ready_i) & ~rst_i;
    end
  endgenerate

  assign w_accept         = in_valid_i & in_ready_o;
  assign w_retire         = r_main_valid & out_ready_i;
  assign w_main_load_in   = w_accept & (~r_main_valid | w_retire) & ~flush_i;
  assign w_main_load_skid = r_skid_valid & w_retire & ~flush_i;
  assign w_skid_load      = (SKID != 0) & w_accept & r_main_valid & ~w_retire & ~flush_i;
  assign w_main_d         = w_main_load_skid ? r_skid : w_in_payload;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_main_load_in || w_main_load_skid) begin
        r_main_valid <= 1'b1;
      end else if (w_retire) begin
        r_main_valid <= 1'b0;
      end
      if (w_skid_load) begin
        r_skid_valid <= 1'b1;
      end else if (w_main_load_skid) begin
        r_skid_valid <= 1'b0;
      end
    end
  end

  pipe_payload_reg #(.T(payload_t)) u_main_reg (
    .clk_i  (clk_i),
    .clr_i  (rst_i),
    .load_i (w_main_load_in | w_main_load_skid),
    .d_i    (w_main_d),
    .q_o    (r_main)
  );

  pipe_payload_reg #(.T(payload_t)) u_skid_reg (
    .clk_i  (clk_i),
    .clr_i  (rst_i),
    .load_i (w_skid_load),
    .d_i    (w_in_payload),
    .q_o    (r_skid)
  );

  // Control fields read as zero on bubbles so MEM/WB never see side effects.
  assign out_valid_o = r_main_valid;
  assign wb_o        = r_main_valid ? r_main.wb : '0;
  assign m_o         = r_main_valid ? r_main.m  : '0;
  assign alu_o       = r_main.alu;
  assign wdata_o     = r_main.wdata;
  assign rd_o        = r_main.rd;
  assign mem_read_o  = m_o[MR_BIT] & out_valid_o;
  assign mem_write_o = m_o[MW_BIT] & out_valid_o;

endmodule

// File: tb/tb_ex_mem_stage_skid.sv
// tb/tb_ex_mem_stage_skid.sv - directed checks of the EX/MEM stage, SKID=1 and SKID=0 builds
module tb_ex_mem_stage_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  wb;
  logic [2:0]  m;
  logic [31:0] alu;
  logic [31:0] wdata;
  logic [4:0]  rd;

  logic        iv, ordy, irdy, ov, mrd, mwr;
  logic [1:0]  wb_q;
  logic [2:0]  m_q;
  logic [31:0] alu_q, wdata_q;
  logic [4:0]  rd_q;

  logic        s0_iv, s0_ordy, s0_irdy, s0_ov, s0_mrd, s0_mwr;
  logic [1:0]  s0_wb_q;
  logic [2:0]  s0_m_q;
  logic [31:0] s0_alu_q, s0_wdata_q;
  logic [4:0]  s0_rd_q;

  int checks = 0;
  int errors = 0;

  ex_mem_stage_skid #(.SKID(1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(iv), .in_ready_o(irdy),
    .wb_i(wb), .m_i(m), .alu_i(alu), .wdata_i(wdata), .rd_i(rd),
    .out_valid_o(ov), .out_ready_i(ordy),
    .wb_o(wb_q), .m_o(m_q), .alu_o(alu_q), .wdata_o(wdata_q), .rd_o(rd_q),
    .mem_read_o(mrd), .mem_write_o(mwr)
  );

  ex_mem_stage_skid #(.SKID(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(s0_iv), .in_ready_o(s0_irdy),
    .wb_i(wb), .m_i(m), .alu_i(alu), .wdata_i(wdata), .rd_i(rd),
    .out_valid_o(s0_ov), .out_ready_i(s0_ordy),
    .wb_o(s0_wb_q), .m_o(s0_m_q), .alu_o(s0_alu_q), .wdata_o(s0_wdata_q), .rd_o(s0_rd_q),
    .mem_read_o(s0_mrd), .mem_write_o(s0_mwr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b0; s0_iv = 1'b0; s0_ordy = 1'b0;
    wb = '0; m = '0; alu = '0; wdata = '0; rd = '0;
    step(); step();
    chk("rst_out_valid", {31'b0, ov}, 32'd0);
    chk("rst_alu", alu_q, 32'd0);
    chk("rst_wb", {30'b0, wb_q}, 32'd0);
    chk("rst_in_ready", {31'b0, irdy}, 32'd0);
    chk("rst_s0_in_ready", {31'b0, s0_irdy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'b0, irdy}, 32'd1);

    // first load, mem-read entry
    iv = 1'b1; alu = 32'h10; m = 3'b010; rd = 5'd5; wb = 2'b11; wdata = 32'hDEAD; ordy = 1'b1;
    step();
    iv = 1'b0;
    chk("t1_out_valid", {31'b0, ov}, 32'd1);
    chk("t1_alu", alu_q, 32'h10);
    chk("t1_mem_read", {31'b0, mrd}, 32'd1);
    chk("t1_mem_write", {31'b0, mwr}, 32'd0);
    chk("t1_rd", {27'b0, rd_q}, 32'd5);
    chk("t1_wb", {30'b0, wb_q}, 32'd3);
    chk("t1_wdata", wdata_q, 32'hDEAD);
    step();
    chk("t1_bubble_valid", {31'b0, ov}, 32'd0);
    chk("t1_bubble_wb", {30'b0, wb_q}, 32'd0);
    chk("t1_bubble_m", {29'b0, m_q}, 32'd0);
    chk("t1_bubble_alu_hold", alu_q, 32'h10);

    // back-to-back stream
    m = 3'b000; wb = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      iv = 1'b1; alu = k;
      step();
      chk($sformatf("stream_alu_%0d", k), alu_q, k);
      chk($sformatf("stream_valid_%0d", k), {31'b0, ov}, 32'd1);
      chk($sformatf("stream_ready_%0d", k), {31'b0, irdy}, 32'd1);
    end
    iv = 1'b0;
    step();
    chk("stream_drain", {31'b0, ov}, 32'd0);

    // skid fill with stalled consumer
    ordy = 1'b0; iv = 1'b1; alu = 32'hA;
    step();
    alu = 32'hB;
    step();
    alu = 32'hC;
    chk("full_in_ready", {31'b0, irdy}, 32'd0);
    chk("full_alu_a", alu_q, 32'hA);
    chk("full_valid", {31'b0, ov}, 32'd1);
    step();
    chk("full_hold_alu", alu_q, 32'hA);
    iv = 1'b0; ordy = 1'b1;
    step();
    chk("drain_alu_b", alu_q, 32'hB);
    chk("drain_ready", {31'b0, irdy}, 32'd1);
    chk("drain_valid_b", {31'b0, ov}, 32'd1);
    step();
    chk("drain_empty", {31'b0, ov}, 32'd0);

    // flush from FULL with store entries
    ordy = 1'b0; iv = 1'b1; m = 3'b001; alu = 32'h20;
    step();
    alu = 32'h21;
    step();
    chk("pre_flush_mwr", {31'b0, mwr}, 32'd1);
    flush = 1'b1; alu = 32'h99;
    step();
    flush = 1'b0; iv = 1'b0;
    chk("flush_valid", {31'b0, ov}, 32'd0);
    chk("flush_m", {29'b0, m_q}, 32'd0);
    chk("flush_mwr", {31'b0, mwr}, 32'd0);
    chk("flush_in_ready", {31'b0, irdy}, 32'd1);
    chk("flush_alu_hold", alu_q, 32'h20);
    step();
    chk("flush_input_ignored", {31'b0, ov}, 32'd0);

    // reset during a held entry
    iv = 1'b1; alu = 32'h55; m = 3'b010; rd = 5'd9;
    step();
    iv = 1'b0;
    chk("held_valid", {31'b0, ov}, 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", {31'b0, ov}, 32'd0);
    chk("mid_rst_alu", alu_q, 32'd0);
    chk("mid_rst_rd", {27'b0, rd_q}, 32'd0);
    chk("mid_rst_mrd", {31'b0, mrd}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, irdy}, 32'd0);
    rst = 1'b0; iv = 1'b1; alu = 32'h66; rd = 5'd7; ordy = 1'b1;
    step();
    iv = 1'b0;
    chk("post_rst_valid", {31'b0, ov}, 32'd1);
    chk("post_rst_alu", alu_q, 32'h66);
    chk("post_rst_rd", {27'b0, rd_q}, 32'd7);
    step();

    // SKID=0 build: combinational ready
    s0_iv = 1'b1; s0_ordy = 1'b0; alu = 32'h70; m = 3'b000;
    step();
    alu = 32'h71;
    chk("s0_valid", {31'b0, s0_ov}, 32'd1);
    chk("s0_alu_70", s0_alu_q, 32'h70);
    chk("s0_ready_stalled", {31'b0, s0_irdy}, 32'd0);
    step();
    chk("s0_hold_70", s0_alu_q, 32'h70);
    s0_ordy = 1'b1;
    #1;
    chk("s0_ready_comb", {31'b0, s0_irdy}, 32'd1);
    step();
    s0_iv = 1'b0;
    chk("s0_replace_71", s0_alu_q, 32'h71);
    chk("s0_valid_71", {31'b0, s0_ov}, 32'd1);
    step();
    chk("s0_drain", {31'b0, s0_ov}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage_skid.md
Name: ex_mem_stage_skid

Overview:
- Parametrised EX/MEM pipeline stage register: captures EX results and carries them to MEM.
- Adds a valid/ready handshake, optional 2-entry skid buffer, flush/bubble insertion and synchronous reset.
- Memory-control bits are decoded into explicit read/write strobes that are gated by valid.
- Sits between the ALU/forwarding muxes and the data memory. Reusable for other stage boundaries by retuning widths.

Parameters:
- DATA_W, 32, width of ALU result and store-data payloads
- WB_W, 2, width of write-back control field
- M_W, 3, width of memory control field
- RD_W, 5, width of destination register index
- MR_BIT, 1, index in m field of the mem-read bit
- MW_BIT, 0, index in m field of the mem-write bit
- SKID, 1, 1 = 2-entry skid buffer (registered in_ready_o); 0 = single register (combinational ready)

Ports:
- clk_i, in, 1, clock
- rst_i, in, 1, synchronous active-high reset
- flush_i, in, 1, discard all held and incoming entries this edge
- in_valid_i, in, 1, EX presents a valid entry
- in_ready_o, out, 1, stage can accept an entry
- wb_i, in, WB_W, write-back control
- m_i, in, M_W, memory control
- alu_i, in, DATA_W, ALU result / address
- wdata_i, in, DATA_W, store data
- rd_i, in, RD_W, destination register
- out_valid_o, out, 1, MEM-side entry valid
- out_ready_i, in, 1, MEM accepts the entry
- wb_o, out, WB_W, registered write-back control; zero when invalid
- m_o, out, M_W, registered memory control; zero when invalid
- alu_o, out, DATA_W, registered ALU result
- wdata_o, out, DATA_W, registered store data
- rd_o, out, RD_W, registered destination
- mem_read_o, out, 1, m_o[MR_BIT] & out_valid_o
- mem_write_o, out, 1, m_o[MW_BIT] & out_valid_o

Behaviour:
- Reset: every output register cleared to 0, main_valid = skid_valid = 0. in_ready_o is 0 while rst_i is high.
- Handshake: accept on in_valid_i & in_ready_o; retire on out_valid_o & out_ready_i. Latency is 1 edge from accept to out_valid_o.
- Payload must not change while out_valid_o & ~out_ready_i; entries are never dropped except by flush or reset.
- SKID=1 states:
  - EMPTY (main 0, skid 0): accept -> load main, go ONE.
  - ONE (main 1, skid 0):
    - accept & retire -> reload main, stay ONE.
    - accept & ~retire -> load skid, go FULL.
    - retire only -> EMPTY.
  - FULL (main 1, skid 1):
    - in_ready_o = 0.
    - retire -> skid moves to main, skid cleared, go ONE.
  - in_ready_o = ~skid_valid registered, so there is no combinational ready path from out_ready_i.
- SKID=0: main register only; in_ready_o = ~out_valid_o | out_ready_i (combinational). This gives full throughput and no skid storage.
- Flush (priority over accept/retire, below reset): both valid bits cleared, wb_o/m_o cleared, and the input that edge is ignored. Next cycle is EMPTY, with in_ready_o = 1.
- Invalid entries (bubbles) always present wb_o = 0 and m_o = 0, so there are no register-file or memory side effects. alu_o/wdata_o/rd_o hold their last value.
- Widths pass through unchanged; no arithmetic.
- Simultaneous cases:
  - accept & retire in ONE keeps full throughput.
  - reset & flush together: reset wins (identical effect).
  - reset mid-transfer drops all in-flight entries.

Decomposition:
- Shared package pipe_pkg: WB/M field widths, MR_BIT/MW_BIT constants, and a typedef ex_mem_payload_t bundling wb, m, alu, wdata, rd.
- Natural sub-module pipe_payload_reg: a load-enabled, clearable payload register, instantiated twice (main and skid). The top module holds the FSM and the muxing.

Test Plan:
- Reset, then in_valid_i=1, alu_i=0x0000_0010, m_i=3'b010, rd_i=5, out_ready_i=1 -> next cycle out_valid_o=1, alu_o=0x10, mem_read_o=1, mem_write_o=0, rd_o=5.
- Stream 0x1,0x2,0x3 back-to-back with out_ready_i=1 -> outputs appear in order 1 cycle later; in_ready_o stays 1 (no bubbles).
- SKID=1: send 0xA, then 0xB with out_ready_i=0 -> FULL, in_ready_o=0, alu_o holds 0xA. Raise out_ready_i -> 0xA then 0xB retire, in_ready_o returns to 1.
- FULL state with m=3'b001 entries, assert flush_i -> next cycle out_valid_o=0, m_o=0, mem_write_o=0, in_ready_o=1; the input presented on the flush edge is not seen.
- Assert rst_i during a held entry (out_ready_i=0) -> next cycle all outputs 0 and in_ready_o=0 while rst_i is high; after release, a fresh accept works normally.
- SKID=0 build, out_ready_i=0 with a held entry -> in_ready_o=0 combinationally. out_ready_i=1 in the same cycle -> in_ready_o=1, new entry replaces the old one.
